// File: rtl/render_sequencer_pkg.sv
// Shared widths, renderer register IDs and sequencer state encoding
// for the render sequencer and its raster counter.
package render_pkg;

    localparam int X_W    = 11;
    localparam int Y_W    = 12;
    localparam int DATA_W = 32;

    localparam logic [2:0] REG_XCOORD = 3'd0;
    localparam logic [2:0] REG_YCOORD = 3'd1;
    localparam logic [2:0] REG_WIDTH  = 3'd2;
    localparam logic [2:0] REG_HEIGHT = 3'd3;
    localparam logic [2:0] REG_COLOR  = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/render_sequencer_scan_counter.sv
// Raster position counter: x runs 0..H_ACTIVE-1, then wraps and advances y.
// last_o flags the final position of the frame.
module scan_counter
    import render_pkg::*;
#(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr_i,
    input  logic           en_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last_o
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/render_sequencer.sv
// Front end of a renderer chain: forwards programming commands as program
// beats while idle, and scans one background-filled frame per request.
module render_sequencer
    import render_pkg::*;
#(
    parameter int          H_ACTIVE = 1920,
    parameter int          V_ACTIVE = 1080,
    parameter logic [31:0] BG_COLOR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [X_W-1:0]    cmd_stage,
    input  logic [2:0]        cmd_reg,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              frame_req,
    output logic              frame_ack,
    output logic              program_out,
    output logic              pix_valid,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

    state_e              state_q, state_d;
    logic                pend_q, pend_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                ack_q, ack_d;
    logic                prog_q, prog_d;
    logic                pv_q, pv_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                done_q, done_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic                scan_en, scan_clr, scan_last;
    logic [X_W-1:0]      scan_x;
    logic [Y_W-1:0]      scan_y;

    scan_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (scan_clr),
        .en_i   (scan_en),
        .x_o    (scan_x),
        .y_o    (scan_y),
        .last_o (scan_last)
    );

    // pend_q marks the cycle after the final beat, where the frame is closed out.
    always_comb begin
        state_d     = state_q;
        pend_d      = 1'b0;
        cmd_ready_d = 1'b0;
        ack_d       = 1'b0;
        prog_d      = 1'b0;
        pv_d        = 1'b0;
        x_d         = '0;
        y_d         = '0;
        data_d      = '0;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        scan_en     = 1'b0;
        scan_clr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    prog_d = 1'b1;
                    x_d    = cmd_stage;
                    y_d    = {9'b0, cmd_reg};
                    data_d = cmd_data;
                end else if (!cmd_valid && frame_req) begin
                    state_d     = ST_SCAN;
                    ack_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    scan_clr    = 1'b1;
                end
            end
            ST_SCAN: begin
                if (pend_q) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    cmd_ready_d = 1'b1;
                end else begin
                    pv_d    = 1'b1;
                    x_d     = scan_x;
                    y_d     = scan_y;
                    data_d  = BG_COLOR;
                    scan_en = 1'b1;
                    pend_d  = scan_last;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            ack_q       <= 1'b0;
            prog_q      <= 1'b0;
            pv_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cmd_ready_q <= cmd_ready_d;
            ack_q       <= ack_d;
            prog_q      <= prog_d;
            pv_q        <= pv_d;
            x_q         <= x_d;
            y_q         <= y_d;
            data_q      <= data_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign frame_ack   = ack_q;
    assign program_out = prog_q;
    assign pix_valid   = pv_q;
    assign x_out       = x_q;
    assign y_out       = y_q;
    assign data_out    = data_q;
    assign frame_done  = done_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_render_sequencer.sv
// Bench for render_sequencer: a queue-based expected-output model checked
// every cycle, a two-stage rectangle renderer chain downstream, and literal checks.
module tb_render_sequencer;

    localparam int          H  = 4;
    localparam int          V  = 2;
    localparam logic [31:0] BG = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [10:0] cmd_stage = '0;
    logic [2:0]  cmd_reg = '0;
    logic [31:0] cmd_data = '0;
    logic        frame_req = 1'b0;
    logic        frame_ack, program_out, pix_valid, frame_done;
    logic [10:0] x_out;
    logic [11:0] y_out;
    logic [31:0] data_out;
    logic [15:0] frame_cnt;

    int total  = 0;
    int passed = 0;

    render_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V), .BG_COLOR(BG)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_stage(cmd_stage), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .frame_req(frame_req), .frame_ack(frame_ack), .program_out(program_out),
        .pix_valid(pix_valid), .x_out(x_out), .y_out(y_out), .data_out(data_out),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rdy;
        logic        ack;
        logic        prog;
        logic        pv;
        logic [10:0] x;
        logic [11:0] y;
        logic [31:0] d;
        logic        done;
    } beat_t;

    function automatic beat_t mk(input logic rdy, input logic ack, input logic prog,
                                 input logic pv, input logic [10:0] x, input logic [11:0] y,
                                 input logic [31:0] d, input logic done);
        beat_t b;
        b.rdy = rdy; b.ack = ack; b.prog = prog; b.pv = pv;
        b.x = x; b.y = y; b.d = d; b.done = done;
        return b;
    endfunction

    // Expected outputs: a frame request schedules its whole output sequence at once.
    beat_t       cur = '0;
    beat_t       sched[$];
    logic [15:0] mcnt = '0;
    bit          live = 1'b0;

    always @(posedge clk) begin
        live = 1'b1;
        if (rst) begin
            sched.delete();
            cur  = '0;
            mcnt = '0;
        end else if (sched.size() > 0) begin
            cur = sched.pop_front();
            if (cur.done) mcnt = mcnt + 16'd1;
        end else if (cmd_valid && cur.rdy) begin
            cur = mk(1, 0, 1, 0, cmd_stage, {9'b0, cmd_reg}, cmd_data, 0);
        end else if (!cmd_valid && frame_req) begin
            cur = mk(0, 1, 0, 0, 11'd0, 12'd0, 32'd0, 0);
            for (int b = 0; b < H * V; b++)
                sched.push_back(mk(0, 0, 0, 1, 11'(b % H), 12'(b / H), BG, 0));
            sched.push_back(mk(1, 0, 0, 0, 11'd0, 12'd0, 32'd0, 1));
        end else begin
            cur = mk(1, 0, 0, 0, 11'd0, 12'd0, 32'd0, 0);
        end
    end

    always @(negedge clk) begin
        if (live) begin
            total++;
            if (cmd_ready === cur.rdy && frame_ack === cur.ack && program_out === cur.prog &&
                pix_valid === cur.pv && x_out === cur.x && y_out === cur.y &&
                data_out === cur.d && frame_done === cur.done && frame_cnt === mcnt)
                passed++;
            else
                $display("FAIL cycle_model t=%0t got rdy%b ack%b prg%b pv%b x%0d y%0d d%h done%b cnt%h want rdy%b ack%b prg%b pv%b x%0d y%0d d%h done%b cnt%h",
                         $time, cmd_ready, frame_ack, program_out, pix_valid, x_out, y_out,
                         data_out, frame_done, frame_cnt, cur.rdy, cur.ack, cur.prog, cur.pv,
                         cur.x, cur.y, cur.d, cur.done, mcnt);
        end
    end

    // Two-stage rectangle renderer chain fed by the sequencer outputs.
    logic [31:0] rr[2][5];
    logic [31:0] chain_pix[H * V];

    always @(negedge clk) begin
        if (rst) begin
            for (int s = 0; s < 2; s++)
                for (int r = 0; r < 5; r++) rr[s][r] = '0;
        end else if (program_out && x_out < 2 && y_out < 5) begin
            rr[x_out[0]][y_out[2:0]] = data_out;
        end else if (pix_valid && x_out < H && y_out < V) begin
            logic [31:0] pd;
            pd = data_out;
            for (int s = 0; s < 2; s++)
                if (x_out >= rr[s][0] && x_out < rr[s][0] + rr[s][2] &&
                    y_out >= rr[s][1] && y_out < rr[s][1] + rr[s][3])
                    pd = rr[s][4];
            chain_pix[y_out * H + x_out] = pd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (frame_ack) return;
        end
        chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (frame_done) return;
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [10:0] st, input logic [2:0] rg, input logic [31:0] dt);
        cmd_valid = 1'b1; cmd_stage = st; cmd_reg = rg; cmd_data = dt;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        // Reset state.
        repeat (2) tick();
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_outs", {29'd0, program_out, pix_valid, frame_done}, 32'd0);
        chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);

        // Single command becomes a program beat the next cycle.
        send(11'd3, 3'd4, 32'h00FF_00FF);
        chk("cmd_prog", {31'd0, program_out}, 32'd1);
        chk("cmd_x", {21'd0, x_out}, 32'd3);
        chk("cmd_y", {20'd0, y_out}, 32'd4);
        chk("cmd_data", data_out, 32'h00FF_00FF);
        tick();
        chk("cmd_gone", {31'd0, program_out}, 32'd0);

        // One frame, no commands.
        frame_req = 1'b1;
        wait_ack();
        frame_req = 1'b0;
        chk("f1_ack", {31'd0, frame_ack}, 32'd1);
        for (int k = 0; k < H * V; k++) begin
            tick();
            chk("f1_beat_xy", {x_out[15:0], 4'd0, y_out}, {16'(k % H), 4'd0, 12'(k / H)});
            chk("f1_beat_d", data_out, BG);
        end
        tick();
        chk("f1_done", {31'd0, frame_done}, 32'd1);
        chk("f1_cnt", {16'd0, frame_cnt}, 32'd1);
        tick();

        // Commands win over a simultaneous frame request; reg IDs 5..7 pass through.
        frame_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_stage = 11'd0; cmd_reg = 3'(5 + i); cmd_data = 32'(i + 100);
            tick();
            chk("b2b_prog", {31'd0, program_out}, 32'd1);
            chk("b2b_reg", {20'd0, y_out}, 32'(5 + i));
        end
        cmd_valid = 1'b0;
        wait_ack();
        frame_req = 1'b0;
        cmd_valid = 1'b1; cmd_reg = 3'd1;
        repeat (5) tick();
        cmd_valid = 1'b0;
        repeat (6) tick();

        // Reset in the middle of a frame.
        frame_req = 1'b1;
        wait_ack();
        frame_req = 1'b0;
        repeat (3) tick();
        chk("abort_at_x2", {21'd0, x_out}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_outs", {29'd0, pix_valid, frame_done, frame_ack}, 32'd0);
        chk("abort_cnt", {16'd0, frame_cnt}, 32'd0);
        repeat (12) tick();
        chk("abort_no_done_cnt", {16'd0, frame_cnt}, 32'd0);

        // Program stage 1 rectangle, then scan through the chain.
        send(11'd1, 3'd0, 32'd1);
        send(11'd1, 3'd1, 32'd0);
        send(11'd1, 3'd2, 32'd2);
        send(11'd1, 3'd3, 32'd1);
        send(11'd1, 3'd4, 32'h1);
        frame_req = 1'b1;
        wait_ack();
        frame_req = 1'b0;
        wait_done();
        chk("chain_0_0", chain_pix[0], BG);
        chk("chain_1_0", chain_pix[1], 32'h1);
        chk("chain_2_0", chain_pix[2], 32'h1);
        chk("chain_3_0", chain_pix[3], BG);
        chk("chain_1_1", chain_pix[5], BG);
        chk("chain_cnt", {16'd0, frame_cnt}, 32'd1);
        tick();

        // Held request restarts right after frame_done.
        frame_req = 1'b1;
        wait_ack();
        wait_done();
        tick();
        chk("restart_ack", {31'd0, frame_ack}, 32'd1);
        frame_req = 1'b0;
        wait_done();
        chk("restart_cnt", {16'd0, frame_cnt}, 32'd3);
        repeat (3) tick();

        // Counter wrap from 16'hFFFF.
        force dut.frame_cnt_q = 16'hFFFF;
        mcnt = 16'hFFFF;
        repeat (2) tick();
        release dut.frame_cnt_q;
        tick();
        chk("preload_cnt", {16'd0, frame_cnt}, 32'h0000_FFFF);
        frame_req = 1'b1;
        wait_ack();
        frame_req = 1'b0;
        wait_done();
        chk("wrap_cnt", {16'd0, frame_cnt}, 32'd0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
